// File: rtl/dram_arbiter.sv
// dram_arbiter: arbitrates a CPU and a host loader/dumper onto one single-port data RAM.
// Optional macro DRAM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed CPU priority.
module dram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              MAIN_CLOCK,
  input  logic              RESET,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  output logic [DATA_W-1:0] CPU_RDATA,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_WDATA,
  output logic              HOST_GNT,
  output logic              HOST_RVALID,
  output logic [DATA_W-1:0] HOST_RDATA,
  input  logic              HOST_LOCK,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WREN,
  output logic [DATA_W-1:0] RAM_DATA,
  input  logic [DATA_W-1:0] RAM_Q,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              who_q, who_d;            // 1: host owns the current access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wren_q, wren_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              host_gnt_q, host_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic cpu_elig_s, host_elig_s, tie_host_s, pick_host_s, start_s;

  assign cpu_elig_s  = CPU_REQ & ~HOST_LOCK;
  assign host_elig_s = HOST_REQ;
  assign start_s     = (state_q == ST_IDLE) && (cpu_elig_s || host_elig_s);

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  logic prio_host_q, prio_host_d;

  // Pointer favours whoever was not granted last.
  always_comb begin
    prio_host_d = prio_host_q;
    if (start_s) begin
      prio_host_d = ~pick_host_s;
    end else begin
      prio_host_d = prio_host_q;
    end
  end

  // Round-robin pointer register; reset favours the CPU.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      prio_host_q <= 1'b0;
    end else begin
      prio_host_q <= prio_host_d;
    end
  end

  assign tie_host_s = prio_host_q;
`else
  assign tie_host_s = 1'b0;
`endif

  // Winner selection among eligible requesters.
  always_comb begin
    pick_host_s = 1'b0;
    if (host_elig_s && cpu_elig_s) begin
      pick_host_s = tie_host_s;
    end else begin
      pick_host_s = host_elig_s;
    end
  end

  // State register plus all registered outputs.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      who_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wren_q        <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      who_q         <= who_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wren_q        <= wren_d;
      cpu_gnt_q     <= cpu_gnt_d;
      host_gnt_q    <= host_gnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start_s ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = we_q ? ST_IDLE : ST_RETURN;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output next values: grant/RAM drive are set up on the IDLE->ACCESS edge so they show during ACCESS.
  always_comb begin
    who_d         = who_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wren_d        = 1'b0;
    cpu_gnt_d     = 1'b0;
    host_gnt_d    = 1'b0;
    cpu_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    host_rdata_d  = host_rdata_q;
    if (start_s) begin
      who_d = pick_host_s;
      if (pick_host_s) begin
        we_d       = HOST_WE;
        addr_d     = HOST_ADDR;
        wdata_d    = HOST_WDATA;
        wren_d     = HOST_WE;
        host_gnt_d = 1'b1;
      end else begin
        we_d      = CPU_WE;
        addr_d    = CPU_ADDR;
        wdata_d   = CPU_WDATA;
        wren_d    = CPU_WE;
        cpu_gnt_d = 1'b1;
      end
    end else if (state_q == ST_RETURN) begin
      if (who_q) begin
        host_rvalid_d = 1'b1;
        host_rdata_d  = RAM_Q;
      end else begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = RAM_Q;
      end
    end else begin
      who_d = who_q;
    end
  end

  assign CPU_GNT     = cpu_gnt_q;
  assign HOST_GNT    = host_gnt_q;
  assign CPU_RVALID  = cpu_rvalid_q;
  assign HOST_RVALID = host_rvalid_q;
  assign CPU_RDATA   = cpu_rdata_q;
  assign HOST_RDATA  = host_rdata_q;
  assign RAM_ADDR    = addr_q;
  assign RAM_DATA    = wdata_q;
  assign RAM_WREN    = wren_q;
  assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Testbench for dram_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model (honours DRAM_ARB_ROUND_ROBIN_EN).
module tb_dram_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              MAIN_CLOCK = 1'b0;
  logic              RESET;
  logic              CPU_REQ, CPU_WE, CPU_GNT, CPU_RVALID;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_WDATA, CPU_RDATA;
  logic              HOST_REQ, HOST_WE, HOST_GNT, HOST_RVALID, HOST_LOCK;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [DATA_W-1:0] HOST_WDATA, HOST_RDATA;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic              RAM_WREN, BUSY;
  logic [DATA_W-1:0] RAM_DATA, RAM_Q;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .MAIN_CLOCK(MAIN_CLOCK), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
    .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA),
    .HOST_GNT(HOST_GNT), .HOST_RVALID(HOST_RVALID), .HOST_RDATA(HOST_RDATA),
    .HOST_LOCK(HOST_LOCK),
    .RAM_ADDR(RAM_ADDR), .RAM_WREN(RAM_WREN), .RAM_DATA(RAM_DATA), .RAM_Q(RAM_Q), .BUSY(BUSY)
  );

  always #5 MAIN_CLOCK = ~MAIN_CLOCK;

  // Single-port synchronous RAM: read data appears one cycle after the address is sampled.
  bit [DATA_W-1:0] ram_mem [0:255];
  always @(posedge MAIN_CLOCK) begin
    if (RAM_WREN) ram_mem[RAM_ADDR] <= RAM_DATA;
    RAM_Q <= ram_mem[RAM_ADDR];
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int              cyc = 0;
  bit              started = 1'b0;
  int              next_sample = 0;
  int              gnt_cyc = -1;
  int              rv_cyc = -1;
  bit              gnt_host, gnt_we, rv_host, m_prio_host;
  logic [ADDR_W-1:0] gnt_addr, m_ram_addr;
  logic [DATA_W-1:0] gnt_data, rv_data, m_ram_data, m_cpu_rdata, m_host_rdata;
  bit [DATA_W-1:0] shadow [0:255];

  always @(negedge MAIN_CLOCK) begin
    bit ce, he, hw;
    cyc++;
    if (started) begin
      if (cyc == gnt_cyc) begin
        m_ram_addr = gnt_addr;
        m_ram_data = gnt_data;
      end
      if (cyc == rv_cyc) begin
        if (rv_host) m_host_rdata = rv_data;
        else         m_cpu_rdata  = rv_data;
      end
      check("cpu_gnt",     32'(CPU_GNT),     32'(cyc == gnt_cyc && !gnt_host));
      check("host_gnt",    32'(HOST_GNT),    32'(cyc == gnt_cyc && gnt_host));
      check("ram_wren",    32'(RAM_WREN),    32'(cyc == gnt_cyc && gnt_we));
      check("ram_addr",    32'(RAM_ADDR),    32'(m_ram_addr));
      check("ram_data",    32'(RAM_DATA),    32'(m_ram_data));
      check("cpu_rvalid",  32'(CPU_RVALID),  32'(cyc == rv_cyc && !rv_host));
      check("host_rvalid", 32'(HOST_RVALID), 32'(cyc == rv_cyc && rv_host));
      check("cpu_rdata",   32'(CPU_RDATA),   32'(m_cpu_rdata));
      check("host_rdata",  32'(HOST_RDATA),  32'(m_host_rdata));
      check("busy",        32'(BUSY),        32'(cyc < next_sample));
    end
    if (RESET) begin
      started      = 1'b1;
      gnt_cyc      = -1;
      rv_cyc       = -1;
      m_ram_addr   = '0;
      m_ram_data   = '0;
      m_cpu_rdata  = '0;
      m_host_rdata = '0;
      m_prio_host  = 1'b0;
      next_sample  = cyc + 1;
    end else if (started && cyc == next_sample) begin
      ce = CPU_REQ && !HOST_LOCK;
      he = HOST_REQ;
      if (ce || he) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        hw = (ce && he) ? m_prio_host : he;
`else
        hw = (ce && he) ? 1'b0 : he;
`endif
        m_prio_host = !hw;
        gnt_cyc  = cyc + 1;
        gnt_host = hw;
        gnt_we   = hw ? HOST_WE : CPU_WE;
        gnt_addr = hw ? HOST_ADDR : CPU_ADDR;
        gnt_data = hw ? HOST_WDATA : CPU_WDATA;
        if (gnt_we) begin
          shadow[gnt_addr] = gnt_data;
          next_sample = cyc + 2;
        end else begin
          rv_cyc  = cyc + 3;
          rv_host = hw;
          rv_data = shadow[gnt_addr];
          next_sample = cyc + 3;
        end
      end else begin
        next_sample = cyc + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge MAIN_CLOCK);
    #2;
  endtask

  initial begin
    int g [4];
    int ng, cg, hg, expg;
    bit cpu_pend, host_pend;
    RESET = 1'b1; HOST_LOCK = 1'b0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
    step(); step();
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_wren", 32'(RAM_WREN), 32'd0);
    check("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
    check("rst_cpu_rdata", 32'(CPU_RDATA), 32'd0);

    // Host write 0x12AB to 0x05 straight out of reset
    RESET = 1'b0;
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 8'h05; HOST_WDATA = 16'h12AB;
    step();
    check("hw_gnt", 32'(HOST_GNT), 32'd1);
    check("hw_wren", 32'(RAM_WREN), 32'd1);
    check("hw_addr", 32'(RAM_ADDR), 32'h05);
    check("hw_data", 32'(RAM_DATA), 32'h12AB);
    HOST_REQ = 1'b0;
    step();
    check("hw_busy_n2", 32'(BUSY), 32'd0);
    check("hw_wren_n2", 32'(RAM_WREN), 32'd0);

    // CPU read back of 0x05
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h05;
    step();
    check("cr_gnt", 32'(CPU_GNT), 32'd1);
    CPU_REQ = 1'b0;
    step();
    check("cr_rvalid_n2", 32'(CPU_RVALID), 32'd0);
    step();
    check("cr_rvalid_n3", 32'(CPU_RVALID), 32'd1);
    check("cr_rdata", 32'(CPU_RDATA), 32'h12AB);
    check("cr_host_rvalid", 32'(HOST_RVALID), 32'd0);
    step();
    check("cr_rdata_hold", 32'(CPU_RDATA), 32'h12AB);

    // Continuous reads from both sides after a fresh reset
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h05;
    HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = 8'h06;
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (CPU_GNT)  begin if (ng < 4) g[ng] = 1; ng++; end
      if (HOST_GNT) begin if (ng < 4) g[ng] = 2; ng++; end
    end
    CPU_REQ = 1'b0; HOST_REQ = 1'b0;
    check("tie_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
      expg = (i % 2 == 0) ? 1 : 2;
`else
      expg = 1;
`endif
      check("tie_winner", 32'(g[i]), 32'(expg));
    end
    for (int i = 0; i < 4; i++) step();

    // HOST_LOCK starves the CPU, host still served
    HOST_LOCK = 1'b1;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h05;
    cg = 0; hg = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (CPU_GNT) cg++;
      if (HOST_GNT) begin hg++; HOST_REQ = 1'b0; end
      if (i == 2) begin
        HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 8'h07; HOST_WDATA = 16'h5A5A;
      end
    end
    check("lock_cpu_gnts", 32'(cg), 32'd0);
    check("lock_host_gnts", 32'(hg), 32'd1);
    HOST_LOCK = 1'b0;
    step();
    check("unlock_cpu_gnt", 32'(CPU_GNT), 32'd1);
    CPU_REQ = 1'b0;
    step(); step(); step();

    // Reset during RETURN aborts the read
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h07;
    step();
    check("ab_gnt", 32'(CPU_GNT), 32'd1);
    CPU_REQ = 1'b0;
    step();
    RESET = 1'b1;
    step();
    check("ab_rvalid", 32'(CPU_RVALID), 32'd0);
    check("ab_busy", 32'(BUSY), 32'd0);
    check("ab_rdata", 32'(CPU_RDATA), 32'd0);
    check("ab_ram_addr", 32'(RAM_ADDR), 32'd0);
    check("ab_ram_data", 32'(RAM_DATA), 32'd0);
    RESET = 1'b0;
    CPU_REQ = 1'b1;
    step();
    check("ab2_gnt", 32'(CPU_GNT), 32'd1);
    CPU_REQ = 1'b0;
    step(); step();
    check("ab2_rvalid", 32'(CPU_RVALID), 32'd1);
    check("ab2_rdata", 32'(CPU_RDATA), 32'h5A5A);

    // Randomized traffic, checked by the model every cycle
    cpu_pend = 1'b0; host_pend = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (CPU_GNT)  cpu_pend  = 1'b0;
      if (HOST_GNT) host_pend = 1'b0;
      if (RESET) RESET = 1'b0;
      else if ($urandom_range(0, 199) == 0) RESET = 1'b1;
      if (!cpu_pend && $urandom_range(0, 2) == 0) begin
        cpu_pend  = 1'b1;
        CPU_WE    = 1'($urandom_range(0, 1));
        CPU_ADDR  = 8'($urandom_range(0, 15));
        CPU_WDATA = 16'($urandom);
      end
      if (!host_pend && $urandom_range(0, 2) == 0) begin
        host_pend  = 1'b1;
        HOST_WE    = 1'($urandom_range(0, 1));
        HOST_ADDR  = 8'($urandom_range(0, 15));
        HOST_WDATA = 16'($urandom);
      end
      CPU_REQ  = cpu_pend;
      HOST_REQ = host_pend;
      if ($urandom_range(0, 19) == 0) HOST_LOCK = ~HOST_LOCK;
    end
    CPU_REQ = 1'b0; HOST_REQ = 1'b0; HOST_LOCK = 1'b0; RESET = 1'b0;
    for (int i = 0; i < 5; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
